seq_magnitude_comparator: RTL and testbench



---
 rtl/seq_magnitude_comparator_pkg.sv | 25 ++
 rtl/seq_magnitude_comparator_if.sv | 29 ++
 rtl/seq_magnitude_comparator_cmp_chunk.sv | 16 +
 rtl/seq_magnitude_comparator.sv | 126 ++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/seq_magnitude_comparator_pkg.sv
// seq_cmp_pkg: shared types and helpers for the sequential magnitude comparator.
//   cmp_state_e : controller states (IDLE, COMPARE, DONE)
//   cmp_res_t   : result encoding {gt, lt, eq} with constants RES_GT/RES_LT/RES_EQ
//   flip_msb    : signed-mode sign-bit inversion applied at operand capture
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } cmp_state_e;

  // Bit order matches the output flags {xgty, xlty, xeqy}.
  typedef logic [2:0] cmp_res_t;
  localparam cmp_res_t RES_GT = 3'b100;
  localparam cmp_res_t RES_LT = 3'b010;
  localparam cmp_res_t RES_EQ = 3'b001;

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so the chunk datapath only ever performs unsigned compares.
  function automatic logic flip_msb(input logic msb, input logic is_signed);
    return msb ^ is_signed;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// seq_magnitude_comparator_if: handshake and data bundle for the comparator.
//   Input side : in_valid, in_ready, x, y, is_signed
//   Output side: out_valid, out_ready, xgty, xlty, xeqy, busy
//   Modports   : master (producer/consumer side), slave (comparator side)
interface seq_magnitude_comparator_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic         xgty;
  logic         xlty;
  logic         xeqy;
  logic         busy;

  modport master (
    output in_valid, x, y, is_signed, out_ready,
    input  in_ready, out_valid, xgty, xlty, xeqy, busy
  );

  modport slave (
    input  in_valid, x, y, is_signed, out_ready,
    output in_ready, out_valid, xgty, xlty, xeqy, busy
  );
endinterface

// File: rtl/seq_magnitude_comparator_cmp_chunk.sv
// cmp_chunk: combinational unsigned comparator for one C-bit chunk.
//   a, b : chunk operands
//   gt   : a > b,  lt : a < b,  eq : a == b
module cmp_chunk #(
  parameter int C = 4
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  output logic         gt,
  output logic         lt,
  output logic         eq
);
  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);
endmodule

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle W-bit magnitude compare, MSB-first,
// one C-bit chunk per clock, unsigned or two's-complement per operation.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of seq_magnitude_comparator_if (valid/ready in,
//           valid/ready out, operands, is_signed, xgty/xlty/xeqy, busy)
// Build option SEQ_CMP_EARLY_EXIT_EN: when defined, COMPARE ends on the first
// differing chunk; otherwise it always runs W/C cycles. Results are identical.
import seq_cmp_pkg::*;

module seq_magnitude_comparator #(
  parameter int W = 32,
  parameter int C = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  seq_magnitude_comparator_if.slave bus
);
  localparam int NC = W / C;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_COMPARE = COMPARE;
  localparam logic [1:0] ST_DONE    = DONE;

  generate
    if ((C < 1) || (C > W) || ((W % C) != 0)) begin : g_param_check
      $error("seq_magnitude_comparator: need 1 <= C <= W and W %% C == 0");
    end
  endgenerate

  logic [1:0]    state;
  logic [W-1:0]  xr;
  logic [W-1:0]  yr;
  logic [IW-1:0] idx;
  logic          decided;
  cmp_res_t      res;

  logic [W-1:0]  xcap;
  logic [W-1:0]  ycap;
  logic [C-1:0]  xc;
  logic [C-1:0]  yc;
  logic          c_gt;
  logic          c_lt;
  logic          c_eq;

  // Capture path: sign-bit flip makes the chunk compare order-correct for signed.
  always_comb begin
    xcap        = bus.x;
    ycap        = bus.y;
    xcap[W-1]   = flip_msb(bus.x[W-1], bus.is_signed);
    ycap[W-1]   = flip_msb(bus.y[W-1], bus.is_signed);
  end

  // Single chunk comparator, fed by an index-driven mux.
  assign xc = xr[int'(idx)*C +: C];
  assign yc = yr[int'(idx)*C +: C];

  cmp_chunk #(.C(C)) u_cmp_chunk (
    .a  (xc),
    .b  (yc),
    .gt (c_gt),
    .lt (c_lt),
    .eq (c_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      xr      <= '0;
      yr      <= '0;
      idx     <= '0;
      decided <= 1'b0;
      res     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            xr      <= xcap;
            yr      <= ycap;
            idx     <= IW'(NC - 1);
            decided <= 1'b0;
            state   <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          // First difference wins; later chunks cannot overwrite it.
          if (!decided && !c_eq) begin
            decided <= 1'b1;
            res     <= c_gt ? RES_GT : RES_LT;
          end else if (!decided && (idx == '0)) begin
            res     <= RES_EQ;
          end
`ifdef SEQ_CMP_EARLY_EXIT_EN
          if ((!decided && !c_eq) || (idx == '0)) begin
            state <= ST_DONE;
          end else begin
            idx <= idx - IW'(1);
          end
`else
          if (idx == '0) begin
            state <= ST_DONE;
          end else begin
            idx <= idx - IW'(1);
          end
`endif
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.xgty      = res[2];
  assign bus.xlty      = res[1];
  assign bus.xeqy      = res[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: directed and randomized bench for the
// sequential magnitude comparator at W=8, C=2 (four chunks).
// Expected flags come from integer arithmetic on the operands; expected
// latency from the position of the highest differing bit.
module tb_seq_magnitude_comparator;
  localparam int W  = 8;
  localparam int C  = 2;
  localparam int NC = W / C;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seq_magnitude_comparator_if #(.W(W)) bus ();

  seq_magnitude_comparator #(.W(W), .C(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference flags {gt, lt, eq} from plain integer comparison.
  function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ia;
    int ib;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    if (ia > ib) return 3'b100;
    if (ia < ib) return 3'b010;
    return 3'b001;
  endfunction

  // Reference latency: chunk holding the highest differing bit, counted from MSB.
  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    logic [7:0] d;
    d = a ^ b;
    for (int p = 7; p >= 0; p--) begin
      if (d[p]) return NC - (p / C);
    end
    return NC;
`else
    return (a == b) ? NC : NC;
`endif
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input int hold, input bit pulse);
    logic [2:0] ef;
    int         el;
    int         cnt;
    ef = ref_flags(a, b, s);
    el = ref_lat(a, b);
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.x         = a;
    bus.y         = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.x         = 8'($urandom);
    bus.y         = 8'($urandom);
    bus.is_signed = 1'($urandom);
    chk("busy_after_accept", 32'({bus.busy, bus.in_ready}), 32'b10);
    cnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(el));
    chk("flags", 32'({bus.xgty, bus.xlty, bus.xeqy}), 32'(ef));
    for (int h = 0; h < hold; h++) begin
      if (h == 0 && pulse) begin
        bus.x        = ~a;
        bus.y        = a;
        bus.in_valid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("hold_flags", 32'({bus.xgty, bus.xlty, bus.xeqy}), 32'(ef));
      chk("hold_ctrl", 32'({bus.out_valid, bus.in_ready, bus.busy}), 32'b101);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_handshake", 32'({bus.out_valid, bus.in_ready, bus.busy}), 32'b010);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        32'({bus.out_valid, bus.xgty, bus.xlty, bus.xeqy, bus.busy, bus.in_ready}),
        32'b000001);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    do_op(8'hA5, 8'hA5, 1'b0, 0, 1'b0);
    do_op(8'h80, 8'h7F, 1'b0, 0, 1'b0);
    do_op(8'h80, 8'h7F, 1'b1, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b1, 0, 1'b0);
    do_op(8'h12, 8'h13, 1'b0, 0, 1'b0);
    do_op(8'h7F, 8'h80, 1'b1, 0, 1'b0);
    // Consumer stall with an ignored in_valid pulse, then a fresh operation.
    do_op(8'h80, 8'h7F, 1'b0, 5, 1'b1);
    do_op(8'h00, 8'hFF, 1'b0, 0, 1'b0);

    // Reset in the middle of COMPARE.
    @(negedge clk);
    bus.x         = 8'h12;
    bus.y         = 8'h13;
    bus.is_signed = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_reset",
        32'({bus.out_valid, bus.xgty, bus.xlty, bus.xeqy, bus.busy, bus.in_ready}),
        32'b000001);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h12, 8'h13, 1'b0, 0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (8'h1 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      do_op(a, b, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
